fifo_capture_ctrl: RTL
======================

Name: fifo_capture_ctrl

Overview:
- Sequences one synchronous sample FIFO (18-bit x 16384, single clock, non-FWFT, registered read data, AFULL at 16380) for one digitizer channel.
- Arms on command and waits for a trigger. Then writes a programmed number of ADC samples into the FIFO.
- After capture, drains the FIFO to a valid/ready stream with frame-last marking, overflow detection and abort.
- Sits between the ADC sample path and the readout/packetizer logic.

Parameters:
- DATA_W, 18: sample and FIFO word width.
- LEN_W, 15: width of SAMPLE_LEN and internal counters; must cover DEPTH.
- DEPTH, 16384: FIFO depth; SAMPLE_LEN values above DEPTH saturate to DEPTH.
- RD_LAT, 1: cycles from FIFO_RE high to FIFO_Q valid. Legal values 1..2.
- SKID_DEPTH, 4: output buffer entries. Must be at least RD_LAT+2.

Ports:
- CLK, in, 1: single clock.
- RESET, in, 1: asynchronous, active-high reset.
- ARM, in, 1: single-cycle start request.
- ABORT, in, 1: single-cycle abort request.
- TRIG, in, 1: trigger qualifier.
- SAMPLE_LEN, in, LEN_W: number of samples to capture; latched on accepted ARM.
- ADC_DATA, in, DATA_W: sample data.
- ADC_VALID, in, 1: sample strobe.
- FIFO_WE, out, 1: FIFO write enable (active-high).
- FIFO_DATA, out, DATA_W: FIFO write data.
- FIFO_RE, out, 1: FIFO read enable (active-high).
- FIFO_Q, in, DATA_W: FIFO read data.
- FIFO_EMPTY, in, 1: FIFO empty flag.
- FIFO_AFULL, in, 1: FIFO almost-full flag.
- FIFO_FULL, in, 1: FIFO full flag.
- OUT_DATA, out, DATA_W: stream data.
- OUT_VALID, out, 1: stream valid.
- OUT_READY, in, 1: stream ready.
- OUT_LAST, out, 1: marks the final word of the frame.
- BUSY, out, 1: high in any state other than IDLE.
- DONE, out, 1: one-cycle pulse when a frame completes.
- OVF_ERR, out, 1: sticky overflow flag; cleared on the next accepted ARM.
- STATE, out, 3: current state encoding for status registers.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters and skid buffer cleared. Every output is 0 at reset, including STATE=0. The FIFO is reset by the same event; RESET_N = ~RESET at integration.
- State encoding: IDLE=0, ARMED=1, CAPTURE=2, DRAIN=3, FLUSH=4.
- IDLE:
  - ARM is accepted only when FIFO_EMPTY=1 and SAMPLE_LEN!=0. On acceptance: latch the length (saturated to DEPTH), clear OVF_ERR and wr_cnt, go to ARMED.
  - ARM is otherwise ignored. TRIG is ignored.
- ARMED:
  - ADC samples are discarded.
  - TRIG=1 goes to CAPTURE. If ADC_VALID=1 in the same cycle, that sample is the first captured: it is written with FIFO_WE in the same cycle.
- CAPTURE:
  - FIFO_WE = ADC_VALID & ~FIFO_AFULL & ~FIFO_FULL, with FIFO_DATA = ADC_DATA. The write is combinational from registered state.
  - wr_cnt increments on each write.
  - When wr_cnt reaches the latched length, go to DRAIN. No write occurs in the cycle after the final write.
  - ADC_VALID=1 with FIFO_AFULL=1: the sample is dropped, OVF_ERR is set, and the state goes to DRAIN. The frame length becomes the current wr_cnt.
- DRAIN:
  - FIFO_RE = ~FIFO_EMPTY & (rd_cnt < wr_cnt) & (skid occupancy + reads in flight < SKID_DEPTH). rd_cnt increments on each FIFO_RE.
  - FIFO_Q is captured into the skid FIFO exactly RD_LAT cycles after each FIFO_RE.
  - OUT_VALID = skid not empty. OUT_DATA and OUT_LAST are taken from the skid head.
  - OUT_LAST=1 on the word whose index is wr_cnt-1.
  - The transfer OUT_VALID & OUT_READY & OUT_LAST goes to IDLE with DONE=1 for one cycle on the following edge.
  - OUT_DATA is held stable while OUT_VALID=1 and OUT_READY=0. No word is lost or duplicated.
- Zero-length frame: if overflow occurs with wr_cnt=0, DRAIN goes directly to IDLE with DONE=1 and no stream output.
- ABORT (any state except IDLE):
  - Skid buffer cleared, OUT_VALID=0 from the next cycle, in-flight read data discarded.
  - Go to FLUSH. In FLUSH, FIFO_RE = ~FIFO_EMPTY; results are discarded.
  - Go to IDLE when FIFO_EMPTY=1 with no read in flight. No DONE pulse.
- Simultaneous events:
  - ABORT has priority over TRIG and over the final write or read.
  - ARM has no effect outside IDLE.
  - ARM and TRIG in the same IDLE cycle: only ARM is acted on.
- Counters are LEN_W bits and never wrap, because the length is bounded by DEPTH.
- FIFO_RE is never asserted when FIFO_EMPTY=1. FIFO_WE is never asserted when FIFO_FULL=1.

Test Plan:
- Basic frame: ARM with SAMPLE_LEN=8, TRIG, ADC ramp 0x00..0x07 continuous, OUT_READY=1 -> 8 words 0..7 out, OUT_LAST on 0x07, DONE one cycle after, then IDLE, BUSY=0.
- Backpressure: SAMPLE_LEN=32, OUT_READY toggled 1,0,1,0 and random gaps -> all 32 words in order, OUT_DATA stable while stalled, skid never exceeds SKID_DEPTH.
- Overflow: SAMPLE_LEN=100, FIFO model forces AFULL after 10 writes -> OVF_ERR=1, exactly 10 words out, LAST on the 10th word, DONE asserted. OVF_ERR clears on the next ARM.
- Abort: SAMPLE_LEN=8, ABORT after 3 words accepted -> no further OUT_VALID, FIFO read until empty, IDLE, DONE never asserted.
- Qualification: TRIG before ARM, ARM while FIFO_EMPTY=0, and ARM with SAMPLE_LEN=0 are all ignored. ADC_VALID gaps during CAPTURE -> only valid samples written. Trigger-cycle sample is captured first.
- Reset: RESET asserted mid-CAPTURE and mid-DRAIN (asynchronously, between edges) -> all outputs 0 immediately, STATE=0. Clean frame after release.

Source files
------------

// File: rtl/fifo_capture_ctrl_if.sv
// Signal bundle between the capture controller and its environment: command/status,
// ADC sample input, sample-FIFO port and the readout stream.
interface fifo_capture_ctrl_if #(
  parameter int DATA_W = 18,
  parameter int LEN_W  = 15
);
  logic              ARM;
  logic              ABORT;
  logic              TRIG;
  logic [LEN_W-1:0]  SAMPLE_LEN;
  logic [DATA_W-1:0] ADC_DATA;
  logic              ADC_VALID;
  logic              FIFO_WE;
  logic [DATA_W-1:0] FIFO_DATA;
  logic              FIFO_RE;
  logic [DATA_W-1:0] FIFO_Q;
  logic              FIFO_EMPTY;
  logic              FIFO_AFULL;
  logic              FIFO_FULL;
  // Stream: a word moves on a rising edge where OUT_VALID & OUT_READY; OUT_VALID never
  // depends on OUT_READY, and OUT_DATA/OUT_LAST hold while OUT_VALID=1 and OUT_READY=0.
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;
  logic              BUSY;
  logic              DONE;
  logic              OVF_ERR;
  logic [2:0]        STATE;

  modport master (
    input  ARM, ABORT, TRIG, SAMPLE_LEN, ADC_DATA, ADC_VALID,
    input  FIFO_Q, FIFO_EMPTY, FIFO_AFULL, FIFO_FULL, OUT_READY,
    output FIFO_WE, FIFO_DATA, FIFO_RE, OUT_DATA, OUT_VALID, OUT_LAST,
    output BUSY, DONE, OVF_ERR, STATE
  );

  modport slave (
    output ARM, ABORT, TRIG, SAMPLE_LEN, ADC_DATA, ADC_VALID,
    output FIFO_Q, FIFO_EMPTY, FIFO_AFULL, FIFO_FULL, OUT_READY,
    input  FIFO_WE, FIFO_DATA, FIFO_RE, OUT_DATA, OUT_VALID, OUT_LAST,
    input  BUSY, DONE, OVF_ERR, STATE
  );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// Arm/trigger/capture/drain sequencer for one digitizer channel's sample FIFO,
// with a small skid buffer that absorbs the FIFO read latency under backpressure.
module fifo_capture_ctrl #(
  parameter int DATA_W     = 18,
  parameter int LEN_W      = 15,
  parameter int DEPTH      = 16384,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4
) (
  input logic CLK,
  input logic RESET,
  fifo_capture_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + RD_LAT + 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] pipe_q;
  logic [DATA_W-1:0] skid_data_q [SKID_DEPTH];
  logic              skid_last_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  skid_cnt_q, inflight;
  logic              we, re, push, pop, flush_skid, out_valid, last_in;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_q[i]);
  end

  assign out_valid = (skid_cnt_q != '0);
  assign pop       = out_valid & bus.OUT_READY;
  // Read data that lands after an abort belongs to a dead frame and is not buffered.
  assign push      = pipe_q[RD_LAT-1] & (state_q == S_DRAIN) & ~flush_skid;
  assign last_in   = (rcv_cnt_q == wr_cnt_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    rcv_cnt_d  = rcv_cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    flush_skid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ARM && bus.FIFO_EMPTY && (bus.SAMPLE_LEN != '0)) begin
          len_d     = (bus.SAMPLE_LEN > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.SAMPLE_LEN;
          ovf_d     = 1'b0;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          rcv_cnt_d = '0;
          state_d   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (bus.ABORT) begin
          flush_skid = 1'b1;
          state_d    = S_FLUSH;
        end else if (bus.TRIG) begin
          state_d = S_CAPTURE;
          if (bus.ADC_VALID && !bus.FIFO_AFULL && !bus.FIFO_FULL) begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            if (wr_cnt_d == len_q) state_d = S_DRAIN;
          end
        end
      end
      S_CAPTURE: begin
        if (bus.ABORT) begin
          flush_skid = 1'b1;
          state_d    = S_FLUSH;
        end else if (bus.ADC_VALID) begin
          if (bus.FIFO_AFULL || bus.FIFO_FULL) begin
            // Truncate the frame at what is already stored.
            ovf_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            if (wr_cnt_d == len_q) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.ABORT) begin
          flush_skid = 1'b1;
          state_d    = S_FLUSH;
        end else if (wr_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          re = !bus.FIFO_EMPTY && (rd_cnt_q < wr_cnt_q) &&
               ((skid_cnt_q + inflight) < CNT_W'(SKID_DEPTH));
          if (re)   rd_cnt_d  = rd_cnt_q + LEN_W'(1);
          if (push) rcv_cnt_d = rcv_cnt_q + LEN_W'(1);
          if (pop && skid_last_q[rp_q]) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        re = !bus.FIFO_EMPTY;
        if (bus.ABORT) flush_skid = 1'b1;
        if (bus.FIFO_EMPTY && (inflight == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rcv_cnt_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      pipe_q[0] <= re;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wp_q       <= '0;
      rp_q       <= '0;
      skid_cnt_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        skid_data_q[i] <= '0;
        skid_last_q[i] <= 1'b0;
      end
    end else if (flush_skid) begin
      wp_q       <= '0;
      rp_q       <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (push) begin
        skid_data_q[wp_q] <= bus.FIFO_Q;
        skid_last_q[wp_q] <= last_in;
        wp_q <= (wp_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
      end
      if (pop) rp_q <= (rp_q == PTR_W'(SKID_DEPTH - 1)) ? '0 : rp_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + CNT_W'(1);
        2'b01:   skid_cnt_q <= skid_cnt_q - CNT_W'(1);
        default: skid_cnt_q <= skid_cnt_q;
      endcase
    end
  end

  assign bus.FIFO_WE   = we;
  assign bus.FIFO_DATA = we ? bus.ADC_DATA : '0;
  assign bus.FIFO_RE   = re;
  assign bus.OUT_VALID = out_valid;
  assign bus.OUT_DATA  = out_valid ? skid_data_q[rp_q] : '0;
  assign bus.OUT_LAST  = out_valid & skid_last_q[rp_q];
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.DONE      = done_q;
  assign bus.OVF_ERR   = ovf_q;
  assign bus.STATE     = state_q;
endmodule
